matrix_split_arb: RTL and testbench

Round-robin scheduler that shares one matrix split engine and its 6-bit per-bank read port between REQ requesters. It sits between the compute clients and the split engine. It validates and latches a requester's row/col counts, issues the engine start, and waits for the engine to finish. It then hands the winning requester exclusive use of the split banks' read address until that requester releases.

---
 rtl/matrix_split_arb.sv | 205 ++++++++++++++++++++
 tb/tb_matrix_split_arb.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_split_arb.sv
// matrix_split_arb
// Round-robin scheduler that shares one matrix split engine and its
// 6-bit per-bank read port between REQ requesters. A winning requester
// has its row/col counts checked and latched. The engine is started and
// the arbiter waits for it to finish. The winner then owns the bank read
// address until it releases.
//
// Optional feature: define SPLIT_ARB_WATCHDOG_EN to add a 14-bit watchdog
// that aborts a job stuck in WAIT_BUSY/WAIT_RDY after TIMEOUT cycles.
// Without the macro those states wait indefinitely.
module matrix_split_arb #(
  parameter int REQ     = 4,
  parameter int CNT     = 64,
  parameter int BIT     = $clog2(CNT),
  parameter int TIMEOUT = 8192
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REQ-1:0]           req_in,
  input  logic [REQ-1:0][BIT:0]    row_cnt_in,
  input  logic [REQ-1:0][BIT:0]    col_cnt_in,
  input  logic [REQ-1:0]           rel_in,
  input  logic [REQ-1:0][5:0]      addrb_in,
  output logic [REQ-1:0]           gnt_out,
  output logic [REQ-1:0]           done_out,
  output logic                     err_out,
  output logic                     split_start_out,
  output logic [BIT:0]             split_row_cnt_out,
  output logic [BIT:0]             split_col_cnt_out,
  input  logic                     split_rdy_in,
  output logic [5:0]               split_addrb_out
);

  localparam int PW = (REQ > 1) ? $clog2(REQ) : 1;
  localparam logic [BIT:0] CNT_MAX  = (BIT+1)'(CNT);
  localparam logic [13:0]  WD_LIMIT = 14'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_RDY  = 3'd3,
    OWN       = 3'd4
  } state_t;

  state_t            state_q;
  logic [PW-1:0]     last_ptr_q;
  logic [PW-1:0]     owner_q;
  logic [REQ-1:0]    gnt_q;
  logic [REQ-1:0]    done_q;
  logic              err_q;
  logic              start_q;
  logic [BIT:0]      row_q;
  logic [BIT:0]      col_q;
  logic [5:0]        addrb_q;

  // Arbitration result for the current cycle.
  logic              win_found;
  logic [PW-1:0]     win_idx;
  logic [REQ-1:0]    win_onehot;
  logic [BIT:0]      win_row;
  logic [BIT:0]      win_col;
  logic              win_ok;

  // Round-robin search: start one past the last winner and wrap modulo REQ.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 1; i <= REQ; i++) begin
      idx = int'(last_ptr_q) + i;
      if (idx >= REQ) begin
        idx = idx - REQ;
      end
      if (!win_found && req_in[idx]) begin
        win_found = 1'b1;
        win_idx   = PW'(idx);
      end
    end
  end

  // Count validation: both counts must be inside 1..CNT.
  always_comb begin
    win_onehot = REQ'(1) << win_idx;
    win_row    = row_cnt_in[win_idx];
    win_col    = col_cnt_in[win_idx];
    win_ok     = (win_row != '0) && (win_row <= CNT_MAX) &&
                 (win_col != '0) && (win_col <= CNT_MAX);
  end

`ifdef SPLIT_ARB_WATCHDOG_EN
  logic [13:0] wd_q;
`else
  // The limit only feeds the watchdog; keep it referenced in this build.
  logic unused_timeout;
  assign unused_timeout = ^WD_LIMIT;
`endif

  // Main scheduler FSM; every output is a register written here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_ptr_q <= PW'(REQ - 1);
      owner_q    <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      start_q    <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      addrb_q    <= '0;
`ifdef SPLIT_ARB_WATCHDOG_EN
      wd_q       <= '0;
`endif
    end else begin
      // Pulses default low; the read address is zero outside OWN.
      done_q  <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      addrb_q <= '0;

      case (state_q)
        IDLE: begin
          if (win_found) begin
            if (!win_ok) begin
              // Reject: report to the winner, advance the pointer, stay idle.
              done_q     <= win_onehot;
              err_q      <= 1'b1;
              last_ptr_q <= win_idx;
            end else if (split_rdy_in) begin
              // Only start the engine once it reports idle (matters after
              // a reset that interrupted a running job).
              owner_q    <= win_idx;
              last_ptr_q <= win_idx;
              row_q      <= win_row;
              col_q      <= win_col;
              gnt_q      <= win_onehot;
              start_q    <= 1'b1;
              state_q    <= START;
            end
          end
        end

        START: begin
          state_q <= WAIT_BUSY;
`ifdef SPLIT_ARB_WATCHDOG_EN
          wd_q    <= '0;
`endif
        end

        WAIT_BUSY: begin
          if (!split_rdy_in) begin
            state_q <= WAIT_RDY;
          end
        end

        WAIT_RDY: begin
          if (split_rdy_in) begin
            state_q <= OWN;
            done_q  <= gnt_q;
            addrb_q <= addrb_in[owner_q];
          end
        end

        OWN: begin
          if (rel_in[owner_q]) begin
            state_q <= IDLE;
            gnt_q   <= '0;
          end else begin
            addrb_q <= addrb_in[owner_q];
          end
        end

        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
        end
      endcase

`ifdef SPLIT_ARB_WATCHDOG_EN
      // Watchdog overrides the normal wait transitions when it expires.
      if (state_q == WAIT_BUSY || state_q == WAIT_RDY) begin
        if (wd_q == WD_LIMIT) begin
          err_q   <= 1'b1;
          gnt_q   <= '0;
          done_q  <= '0;
          addrb_q <= '0;
          state_q <= IDLE;
        end else begin
          wd_q <= wd_q + 14'd1;
        end
      end
`endif
    end
  end

  assign gnt_out           = gnt_q;
  assign done_out          = done_q;
  assign err_out           = err_q;
  assign split_start_out   = start_q;
  assign split_row_cnt_out = row_q;
  assign split_col_cnt_out = col_q;
  assign split_addrb_out   = addrb_q;

endmodule

// File: tb/tb_matrix_split_arb.sv
// Testbench for matrix_split_arb: table of jobs/rejections plus
// hand-written reset-mid-job and watchdog sequences, with a small
// behavioural split engine.
module tb_matrix_split_arb;

  localparam int REQ = 4;
  localparam int CNT = 64;
  localparam int BIT = 6;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [REQ-1:0]        req_in;
  logic [REQ-1:0][BIT:0] row_cnt_in;
  logic [REQ-1:0][BIT:0] col_cnt_in;
  logic [REQ-1:0]        rel_in;
  logic [REQ-1:0][5:0]   addrb_in;
  logic [REQ-1:0]        gnt_out;
  logic [REQ-1:0]        done_out;
  logic                  err_out;
  logic                  split_start_out;
  logic [BIT:0]          split_row_cnt_out;
  logic [BIT:0]          split_col_cnt_out;
  logic                  split_rdy_in;
  logic [5:0]            split_addrb_out;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  matrix_split_arb #(.REQ(REQ), .CNT(CNT), .BIT(BIT), .TIMEOUT(50)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_in            (req_in),
    .row_cnt_in        (row_cnt_in),
    .col_cnt_in        (col_cnt_in),
    .rel_in            (rel_in),
    .addrb_in          (addrb_in),
    .gnt_out           (gnt_out),
    .done_out          (done_out),
    .err_out           (err_out),
    .split_start_out   (split_start_out),
    .split_row_cnt_out (split_row_cnt_out),
    .split_col_cnt_out (split_col_cnt_out),
    .split_rdy_in      (split_rdy_in),
    .split_addrb_out   (split_addrb_out)
  );

  // Engine model: goes busy when it samples start, idle again after
  // eng_busy cycles unless stalled.
  logic eng_rdy = 1'b1;
  int   eng_cnt = 0;
  bit   eng_stall = 1'b0;
  int   eng_busy = 20;
  assign split_rdy_in = eng_rdy;

  always @(posedge clk) begin
    if (split_start_out && eng_rdy) begin
      eng_rdy <= 1'b0;
      eng_cnt <= eng_busy;
    end else if (!eng_rdy && !eng_stall) begin
      if (eng_cnt <= 1) eng_rdy <= 1'b1;
      else              eng_cnt <= eng_cnt - 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [REQ-1:0] req;
    logic [BIT:0]   row;
    logic [BIT:0]   col;
    logic [REQ-1:0] exp;
    bit             reject;
    bit             drop;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];

  task automatic run_vec(input int id, input vec_t v);
    int owner;
    int n;
    int starts;
    owner = 0;
    for (int k = 0; k < REQ; k++) begin
      row_cnt_in[k] = v.row;
      col_cnt_in[k] = v.col;
      if (v.exp[k]) owner = k;
    end
    req_in = v.req;
    tick();
    if (v.reject) begin
      check("rej_done", 32'(done_out), 32'(v.exp));
      check("rej_err", 32'(err_out), 32'd1);
      check("rej_gnt", 32'(gnt_out), 32'd0);
      check("rej_start", 32'(split_start_out), 32'd0);
      req_in = '0;
      tick();
      check("rej_pulse", 32'({done_out, err_out, gnt_out}), 32'd0);
      $display("txn %0d req=%b row=%0d col=%0d rejected done=%b", id, v.req, v.row, v.col, v.exp);
    end else begin
      check("gnt", 32'(gnt_out), 32'(v.exp));
      check("start", 32'(split_start_out), 32'd1);
      check("row_cnt", 32'(split_row_cnt_out), 32'(v.row));
      check("col_cnt", 32'(split_col_cnt_out), 32'(v.col));
      if (v.drop) req_in = '0;
      starts = 0;
      n = 0;
      tick();
      while (done_out == '0 && n < 200) begin
        if (split_start_out) starts++;
        n++;
        tick();
      end
      check("done", 32'(done_out), 32'(v.exp));
      check("single_start", 32'(starts), 32'd0);
      check("gnt_own", 32'(gnt_out), 32'(v.exp));
      check("row_hold", 32'(split_row_cnt_out), 32'(v.row));
      // Isolation: non-owner release and non-owner address must be ignored.
      for (int k = 0; k < REQ; k++) addrb_in[k] = 6'd9;
      addrb_in[owner] = 6'(5 + owner);
      rel_in = {v.exp[REQ-2:0], v.exp[REQ-1]};
      tick();
      check("addrb", 32'(split_addrb_out), 32'(5 + owner));
      check("iso_gnt", 32'(gnt_out), 32'(v.exp));
      check("done_pulse", 32'(done_out), 32'd0);
      rel_in = '0;
      addrb_in[owner] = 6'h2a;
      tick();
      check("addrb2", 32'(split_addrb_out), 32'h2a);
      rel_in = v.exp;
      tick();
      rel_in = '0;
      check("rel_gnt", 32'(gnt_out), 32'd0);
      check("rel_addrb", 32'(split_addrb_out), 32'd0);
      $display("txn %0d req=%b row=%0d col=%0d granted=%b", id, v.req, v.row, v.col, v.exp);
    end
  endtask

  initial begin
    int n;
    int starts;
    int hit;

    tbl[0]  = '{4'b0001, 7'd4,   7'd3,  4'b0001, 1'b0, 1'b0};
    tbl[1]  = '{4'b1111, 7'd1,   7'd64, 4'b0010, 1'b0, 1'b0};
    tbl[2]  = '{4'b1111, 7'd64,  7'd1,  4'b0100, 1'b0, 1'b0};
    tbl[3]  = '{4'b1111, 7'd7,   7'd9,  4'b1000, 1'b0, 1'b0};
    tbl[4]  = '{4'b1111, 7'd2,   7'd2,  4'b0001, 1'b0, 1'b0};
    tbl[5]  = '{4'b1111, 7'd10,  7'd11, 4'b0010, 1'b0, 1'b0};
    tbl[6]  = '{4'b1010, 7'd3,   7'd5,  4'b1000, 1'b0, 1'b0};
    tbl[7]  = '{4'b0100, 7'd4,   7'd0,  4'b0100, 1'b1, 1'b0};
    tbl[8]  = '{4'b0100, 7'd4,   7'd65, 4'b0100, 1'b1, 1'b0};
    tbl[9]  = '{4'b0100, 7'd0,   7'd3,  4'b0100, 1'b1, 1'b0};
    tbl[10] = '{4'b0100, 7'd127, 7'd5,  4'b0100, 1'b1, 1'b0};
    tbl[11] = '{4'b0101, 7'd64,  7'd64, 4'b0001, 1'b0, 1'b0};
    tbl[12] = '{4'b0101, 7'd1,   7'd1,  4'b0100, 1'b0, 1'b1};
    tbl[13] = '{4'b0011, 7'd65,  7'd1,  4'b0001, 1'b1, 1'b0};
    tbl[14] = '{4'b0011, 7'd9,   7'd63, 4'b0010, 1'b0, 1'b0};

    rst = 1'b1;
    req_in = '0;
    row_cnt_in = '0;
    col_cnt_in = '0;
    rel_in = '0;
    addrb_in = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_outs", 32'({gnt_out, done_out, err_out, split_start_out, split_addrb_out}), 32'd0);
    check("reset_cnts", 32'({split_row_cnt_out, split_col_cnt_out}), 32'd0);

    for (int i = 0; i < NV; i++) run_vec(i, tbl[i]);

    // Reset while the engine is busy (arbiter in WAIT_RDY).
    eng_stall = 1'b1;
    for (int k = 0; k < REQ; k++) begin
      row_cnt_in[k] = 7'd4;
      col_cnt_in[k] = 7'd3;
    end
    req_in = 4'b0010;
    tick();
    check("rst_job_gnt", 32'(gnt_out), 32'b0010);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_outs", 32'({gnt_out, done_out, err_out, split_start_out, split_addrb_out}), 32'd0);
    check("rst_mid_cnts", 32'({split_row_cnt_out, split_col_cnt_out}), 32'd0);
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (gnt_out != '0 || split_start_out) starts++;
    end
    check("rst_no_start_busy", 32'(starts), 32'd0);
    eng_stall = 1'b0;
    n = 0;
    while (gnt_out == '0 && n < 100) begin
      tick();
      n++;
    end
    check("rst_regrant", 32'(gnt_out), 32'b0010);
    check("rst_regrant_start", 32'(split_start_out), 32'd1);
    req_in = '0;
    n = 0;
    while (done_out == '0 && n < 200) begin
      tick();
      n++;
    end
    check("rst_job_done", 32'(done_out), 32'b0010);
    rel_in = 4'b0010;
    tick();
    rel_in = '0;
    check("rst_job_rel", 32'(gnt_out), 32'd0);
    $display("txn rst_mid_job regrant=%b", 4'b0010);

`ifdef SPLIT_ARB_WATCHDOG_EN
    // Watchdog: engine never returns idle, abort after 50 cycles.
    eng_stall = 1'b1;
    req_in = 4'b0001;
    tick();
    check("wd_gnt", 32'(gnt_out), 32'b0001);
    req_in = '0;
    hit = 0;
    starts = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (done_out != '0) starts++;
      if (err_out && hit == 0) begin
        hit = i;
        check("wd_gnt_clear", 32'(gnt_out), 32'd0);
      end
    end
    check("wd_err_cycle", 32'(hit), 32'd51);
    check("wd_no_done", 32'(starts), 32'd0);
    eng_stall = 1'b0;
    n = 0;
    while (!eng_rdy && n < 100) begin
      tick();
      n++;
    end
    $display("txn watchdog abort_cycle=%0d", hit);
`else
    hit = 0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
